// File: rtl/xram_pkg.sv
// Shared constants for the XRAM controller: FSM encoding, default
// parameter values and the address window test.
package xram_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_ACK  = 2'b10;

  localparam logic [15:0] XRAM_BASE_DEF     = 16'h0000;
  localparam int          XRAM_AW_DEF       = 10;
  localparam int          XRAM_WAIT_CYC_DEF = 2;
  localparam int          XRAM_DATA_W       = 8;

  // True when base <= addr < base + 2^aw. Done in 17 bits so a window
  // that ends exactly at the top of the 16-bit space does not wrap.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int          aw);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {1'b0, base};
    hi = {1'b0, base} + (17'd1 << aw);
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/xram_bank.sv
// Single-port synchronous byte RAM with registered read data.
// Contents are not reset.
module xram_bank
  import xram_pkg::*;
#(
  parameter int AW     = XRAM_AW_DEF,
  parameter int DATA_W = XRAM_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  // Write on we; read data is the pre-write contents, registered.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/xram_ctrl.sv
// Two-port XRAM controller: round-robin arbiter, wait-state FSM and
// address window check in front of a single byte RAM bank.
module xram_ctrl
  import xram_pkg::*;
#(
  parameter logic [15:0] BASE     = XRAM_BASE_DEF,
  parameter int          AW       = XRAM_AW_DEF,
  parameter int          WAIT_CYC = XRAM_WAIT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p0_data_in,
  input  logic [7:0]  p1_data_in,
  input  logic        p0_stb,
  input  logic        p1_stb,
  input  logic        p0_wr,
  input  logic        p1_wr,
  output logic [7:0]  p0_data_out,
  output logic [7:0]  p1_data_out,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        err,
  output logic [1:0]  state,
  output logic        gnt
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  logic [1:0]    state_q;
  logic [3:0]    cnt_q;
  logic          gnt_q;
  logic          last_q;

  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [7:0]    wdata_q;
  logic          inr_q;

  logic          any_stb;
  logic          sel;
  logic [15:0]   sel_addr;
  logic [AW-1:0] sel_idx;
  logic          gnt_stb;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          in_ack;
  logic          rd_ok;

  // On a tie the port that was not served last wins.
  assign any_stb  = p0_stb | p1_stb;
  assign sel      = (p0_stb && p1_stb) ? ~last_q : p1_stb;
  assign sel_addr = sel ? p1_addr : p0_addr;
  assign sel_idx  = AW'(sel_addr - BASE);
  assign gnt_stb  = gnt_q ? p1_stb : p0_stb;

  // In IDLE the RAM address comes straight from the winning port so that a
  // zero-wait access still has its read data captured on the edge into ACK.
  assign ram_addr = (state_q == ST_IDLE) ? sel_idx : idx_q;
  assign in_ack   = (state_q == ST_ACK);
  assign ram_we   = in_ack && wr_q && inr_q;
  assign rd_ok    = in_ack && !wr_q && inr_q;

  xram_bank #(
    .AW     (AW),
    .DATA_W (8)
  ) u_bank (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Control FSM: arbitration, wait countdown, abort and last-served update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_stb) begin
            gnt_q   <= sel;
            cnt_q   <= WAIT_LD;
            state_q <= (WAIT_LD == 4'd0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!gnt_stb) begin
            cnt_q   <= 4'd0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          last_q  <= gnt_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Request capture: address, direction and write data frozen at grant.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && any_stb) begin
      idx_q   <= sel_idx;
      wr_q    <= sel ? p1_wr : p0_wr;
      wdata_q <= sel ? p1_data_in : p0_data_in;
      inr_q   <= in_window(sel_addr, BASE, AW);
    end
  end

  assign p0_ack      = in_ack && !gnt_q;
  assign p1_ack      = in_ack &&  gnt_q;
  assign err         = in_ack && !inr_q;
  assign p0_data_out = (rd_ok && !gnt_q) ? ram_rdata : 8'h00;
  assign p1_data_out = (rd_ok &&  gnt_q) ? ram_rdata : 8'h00;
  assign state       = state_q;
  assign gnt         = gnt_q;

endmodule

// File: tb/tb_xram_ctrl.sv
// Scoreboard bench for xram_ctrl: directed scenarios plus randomized
// traffic against a behavioural memory/arbitration model.
module tb_xram_ctrl;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_data_in, p1_data_in;
  logic        p0_stb, p1_stb, p0_wr, p1_wr;
  logic [7:0]  p0_data_out, p1_data_out;
  logic        p0_ack, p1_ack, err, gnt;
  logic [1:0]  state;

  logic [15:0] z_p0_addr, z_p1_addr;
  logic [7:0]  z_p0_data_in, z_p1_data_in;
  logic        z_p0_stb, z_p1_stb, z_p0_wr, z_p1_wr;
  logic [7:0]  z_p0_data_out, z_p1_data_out;
  logic        z_p0_ack, z_p1_ack, z_err, z_gnt;
  logic [1:0]  z_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  xram_ctrl #(.BASE(16'h0000), .AW(10), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_data_in(p0_data_in), .p1_data_in(p1_data_in),
    .p0_stb(p0_stb), .p1_stb(p1_stb), .p0_wr(p0_wr), .p1_wr(p1_wr),
    .p0_data_out(p0_data_out), .p1_data_out(p1_data_out),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .err(err), .state(state), .gnt(gnt)
  );

  xram_ctrl #(.BASE(16'h0000), .AW(10), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .p0_addr(z_p0_addr), .p1_addr(z_p1_addr),
    .p0_data_in(z_p0_data_in), .p1_data_in(z_p1_data_in),
    .p0_stb(z_p0_stb), .p1_stb(z_p1_stb), .p0_wr(z_p0_wr), .p1_wr(z_p1_wr),
    .p0_data_out(z_p0_data_out), .p1_data_out(z_p1_data_out),
    .p0_ack(z_p0_ack), .p1_ack(z_p1_ack), .err(z_err), .state(z_state), .gnt(z_gnt)
  );

  typedef struct {
    bit       port;
    bit       chk_data;
    bit [7:0] data;
    bit       err;
    int       cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: flat byte array for the 1 KiB window, validity flags
  // because RAM contents are undefined until written, and last-served port.
  bit [7:0] ref_mem [0:1023];
  bit       ref_vld [0:1023];
  bit       ref_last = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_inr(input bit [15:0] a);
    int ai;
    ai = int'(a);
    return (ai >= 0) && (ai < 0 + 1024);
  endfunction

  task automatic model_serve(input bit port, input bit wr, input bit [15:0] a,
                             input bit [7:0] d, input int ack_cyc);
    exp_t e;
    e.port = port; e.cyc = ack_cyc; e.err = !ref_inr(a);
    e.data = 8'h00; e.chk_data = 1'b1;
    if (!wr && ref_inr(a)) begin
      if (ref_vld[a[9:0]]) e.data = ref_mem[a[9:0]];
      else e.chk_data = 1'b0;
    end
    if (wr && ref_inr(a)) begin
      ref_mem[a[9:0]] = d;
      ref_vld[a[9:0]] = 1'b1;
    end
    ref_last = port;
    sbq.push_back(e);
  endtask

  // Monitor: every ack pops the oldest expectation and compares it.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (p0_ack || p1_ack) begin
        check("ack_exclusive", {31'd0, p0_ack & p1_ack}, 32'd0);
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: p0_ack=%0b p1_ack=%0b with none expected", p0_ack, p1_ack);
        end else begin
          mon_e = sbq.pop_front();
          check("ack_port", {31'd0, p1_ack}, {31'd0, mon_e.port});
          check("ack_cycle", cyc, mon_e.cyc);
          check("ack_err", {31'd0, err}, {31'd0, mon_e.err});
          if (mon_e.chk_data)
            check("rd_data", {24'd0, p1_ack ? p1_data_out : p0_data_out}, {24'd0, mon_e.data});
          check("other_dout_zero", {24'd0, p1_ack ? p0_data_out : p1_data_out}, 32'd0);
        end
      end else if (err) begin
        check("err_without_ack", {31'd0, err}, 32'd0);
      end
    end
  end

  // Issue one or two simultaneous requests at a negedge with the DUT idle,
  // hold each strobe until its ack, then leave one idle cycle.
  task automatic access(input bit u0, input bit u1, input bit wr0, input bit wr1,
                        input bit [15:0] a0, input bit [15:0] a1,
                        input bit [7:0] d0, input bit [7:0] d1, input bit scramble);
    int  c;
    int  t;
    bit  first;
    c = cyc;
    first = (u0 && u1) ? !ref_last : u1;
    if (!first) begin
      if (u0) model_serve(1'b0, wr0, a0, d0, c + WC + 1);
      if (u1) model_serve(1'b1, wr1, a1, d1, c + WC + 1 + (u0 ? WC + 2 : 0));
    end else begin
      model_serve(1'b1, wr1, a1, d1, c + WC + 1);
      if (u0) model_serve(1'b0, wr0, a0, d0, c + WC + 1 + WC + 2);
    end
    p0_stb = u0; p0_wr = wr0; p0_addr = a0; p0_data_in = d0;
    p1_stb = u1; p1_wr = wr1; p1_addr = a1; p1_data_in = d1;
    t = 0;
    while ((p0_stb || p1_stb) && t < 40) begin
      @(negedge clk);
      t++;
      if (p0_ack) p0_stb = 1'b0;
      if (p1_ack) p1_stb = 1'b0;
      if (scramble && !(u0 && u1)) begin
        p0_addr = 16'($urandom); p0_data_in = 8'($urandom); p0_wr = 1'($urandom);
        p1_addr = 16'($urandom); p1_data_in = 8'($urandom); p1_wr = 1'($urandom);
      end
    end
    if (p0_stb || p1_stb) begin
      checks++; errors++;
      $display("FAIL ack_timeout: p0_stb=%0b p1_stb=%0b still pending after 40 cycles", p0_stb, p1_stb);
      p0_stb = 1'b0; p1_stb = 1'b0;
      sbq.delete();
    end
    @(negedge clk);
  endtask

  function automatic bit [15:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 16'($urandom_range(0, 31));
    else if (r == 7) return 16'h03FF;
    else return 16'($urandom_range(16'h0400, 16'hFFFF));
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int zc;
    bit prev;
    rst = 1'b0;
    p0_addr = 0; p1_addr = 0; p0_data_in = 0; p1_data_in = 0;
    p0_stb = 0; p1_stb = 0; p0_wr = 0; p1_wr = 0;
    z_p0_addr = 0; z_p1_addr = 0; z_p0_data_in = 0; z_p1_data_in = 0;
    z_p0_stb = 0; z_p1_stb = 0; z_p0_wr = 0; z_p1_wr = 0;
    repeat (3) @(negedge clk);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_gnt", {31'd0, gnt}, 32'd0);
    check("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dout", {16'd0, p1_data_out, p0_data_out}, 32'd0);
    check("rst_state_z", {30'd0, z_state}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // First tie after reset goes to port 0, the repeat to port 1.
    access(1, 1, 0, 0, 16'h0010, 16'h0020, 0, 0, 0);
    access(1, 1, 0, 0, 16'h0010, 16'h0020, 0, 0, 0);

    // Write then read back on port 0.
    access(1, 0, 1, 0, 16'h0005, 0, 8'hA5, 0, 0);
    access(1, 0, 0, 0, 16'h0005, 0, 0, 0, 0);

    // Preload the low window through both ports.
    for (int i = 0; i < 32; i++) begin
      if (i == 5) continue;
      if (i % 2 == 0) access(1, 0, 1, 0, 16'(i), 0, 8'($urandom), 0, 0);
      else            access(0, 1, 0, 1, 0, 16'(i), 0, 8'($urandom), 0);
    end

    // Out-of-range read and write.
    access(1, 0, 0, 0, 16'h0400, 0, 0, 0, 0);
    access(1, 0, 1, 0, 16'h0400, 0, 8'h11, 0, 0);
    access(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);

    // Port 1 write abandoned during WAIT.
    p1_stb = 1; p1_wr = 1; p1_addr = 16'h0007; p1_data_in = 8'hEE;
    @(negedge clk);
    p1_stb = 0;
    @(negedge clk);
    check("abort_state_idle", {30'd0, state}, 32'd0);
    @(negedge clk);
    access(0, 1, 0, 0, 0, 16'h0007, 0, 0, 0);

    // Reset in the middle of a write.
    p0_stb = 1; p0_wr = 1; p0_addr = 16'h0003; p0_data_in = 8'h77;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_state", {30'd0, state}, 32'd0);
    check("midrst_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
    p0_stb = 0;
    ref_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("midrst_no_pending", sbq.size(), 32'd0);
    @(negedge clk);
    access(1, 0, 0, 0, 16'h0003, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      int m;
      m = $urandom_range(0, 2);
      access(m != 1, m != 0, 1'($urandom), 1'($urandom), rnd_addr(), rnd_addr(),
             8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Zero-wait instance: strobe held for 64 cycles gives 32 acks, alternating.
    z_p0_addr = 16'h0010; z_p0_wr = 0; z_p0_stb = 1;
    zc = 0; prev = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      check("z_ack_pattern", {31'd0, z_p0_ack}, 32'(i % 2));
      if (z_p0_ack) begin
        zc++;
        check("z_err", {31'd0, z_err}, 32'd0);
        if (prev) check("z_no_consecutive", 32'd1, 32'd0);
      end
      prev = z_p0_ack;
    end
    z_p0_stb = 0;
    check("z_ack_count", zc, 32'd32);
    repeat (3) @(negedge clk);

    check("sb_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xram_ctrl.md
XRAM_CTRL -- requirements
Module: xram_ctrl

Interface
REQ-001 SHALL have parameter BASE, default 16'h0000, first XRAM byte address served.
REQ-002 SHALL have parameter AW, default 10, memory address width (depth 2^AW bytes).
REQ-003 SHALL have parameter WAIT_CYC, default 2, wait cycles inserted before each ack (0..15).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 p0_addr, p1_addr  input  16  per-port XRAM byte address.
REQ-008 p0_data_in, p1_data_in  input  8  per-port write data.
REQ-009 p0_stb, p1_stb  input  1  per-port request, held until acked.
REQ-010 p0_wr, p1_wr  input  1  per-port 1 = write, 0 = read.
REQ-011 p0_data_out, p1_data_out  output  8  read data, valid only in that port's ack cycle.
REQ-012 p0_ack, p1_ack  output  1  single-cycle completion pulse.
REQ-013 err  output  1  one-cycle pulse with an ack whose address is out of range.
REQ-014 state  output  2  current FSM state (verification).
REQ-015 gnt  output  1  port currently/last granted (verification).

Function
REQ-016 States: IDLE=2'b00, WAIT=2'b01, ACK=2'b10; 2'b11 unreachable, SHALL decode to IDLE.
REQ-017 IDLE: no stb -> stay; any stb -> latch granted port's addr/wr/data_in, load wait counter with WAIT_CYC, go WAIT (or ACK if WAIT_CYC=0).
REQ-018 Arbitration: single stb -> that port; both stb -> port != last-served port (round robin).
REQ-019 WAIT: decrement counter each cycle; counter reaching 0 -> ACK.
REQ-020 Granted port's stb low in WAIT -> abort to IDLE, no ack, no write, last-served unchanged.
REQ-021 ACK: exactly one cycle; assert granted port's ack only; next state IDLE unconditionally.
REQ-022 Read: memory byte captured on the edge entering ACK; driven on granted port's data_out during ACK; data_out = 8'h00 otherwise.
REQ-023 Write: memory updated on the edge leaving ACK with latched data; read issued later to same address returns new byte.
REQ-024 In range: BASE <= addr < BASE + 2^AW (16-bit compare, no wrap); index = addr - BASE, low AW bits.
REQ-025 Out of range: still acked with normal latency; read returns 8'h00; write dropped; err high during ACK.
REQ-026 Latency: stb seen in IDLE at cycle t -> ack at cycle t+WAIT_CYC+1; back-to-back same-port throughput one access per WAIT_CYC+2 cycles.
REQ-027 Ungranted port's ack stays 0; its request is served after the current access completes.
REQ-028 Address/data changes on granted port after latch SHALL NOT affect the access in flight.
REQ-029 last-served updated on ACK only.

Reset
REQ-030 rst low: state=IDLE, acks=0, err=0, data_outs=8'h00, wait counter=0, last-served=1 (port 0 wins first tie), gnt=0.
REQ-031 Reset mid-access: access discarded, no ack, no memory write; memory contents not reset, undefined after power-up.

Structure
REQ-032 Package xram_pkg SHALL hold state encoding constants, default BASE/AW/WAIT_CYC values.
REQ-033 Sub-module xram_bank SHALL implement the synchronous byte RAM (one read/write port, registered read).
REQ-034 Arbiter, FSM, wait counter, range check SHALL live in xram_ctrl.

Verification
REQ-035 Write p0 addr 16'h0005 data 8'hA5, then read p0 16'h0005 -> second ack at t+3 with p0_data_out=8'hA5, err=0.
REQ-036 p0 and p1 stb same cycle after reset (reads 16'h0010, 16'h0020) -> p0 acked first, p1 acked 4 cycles later; repeat tie -> p1 first.
REQ-037 Read 16'h0400 (BASE=0, AW=10) -> ack with data_out=8'h00, err=1; write 16'h0400 8'h11 then read 16'h0000 -> unchanged.
REQ-038 p1 stb dropped in WAIT -> no p1_ack, state IDLE next cycle, memory unchanged.
REQ-039 rst low during WAIT of write 16'h0003 8'h77 -> no ack, state=IDLE; subsequent read 16'h0003 returns prior value.
REQ-040 WAIT_CYC=0: 32 back-to-back p0 reads -> ack every 2nd cycle, never two consecutive acks.
